// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte-enable support is selected with the DMEM_BYTE_EN macro.
package dmem_pkg;

    localparam int WORD_W = 32;

    // Bit positions inside the error-cause vector, kept for debug visibility.
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_W        = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write with a per-byte mask, combinational read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        wmask_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Write only the byte lanes selected by the mask.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory request interface.
// Serves one load or store at a time after WAIT_STATES wait cycles.
// Define DMEM_BYTE_EN to add the be_i port and byte-masked stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]        be_i,
`endif
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
`ifdef DMEM_BYTE_EN
    logic [3:0]        be_q;
`endif

    logic [ERR_W-1:0]  errCause;
    logic              isErr;
    logic [3:0]        wmask;
    logic              memWe;
    logic [AW-1:0]     wordIdx;
    logic [WORD_W-1:0] memRdata;

    // Request capture, wait-state countdown and one-cycle response sequencing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_EN
            be_q    <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
`ifdef DMEM_BYTE_EN
                        be_q    <= be_i;
`endif
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Error classification and write mask, all taken from the captured request.
    always_comb begin
        errCause = '0;
        wmask    = 4'hF;
`ifdef DMEM_BYTE_EN
        wmask                  = be_q;
        errCause[ERR_MISALIGN] = (be_q == 4'hF) && (addr_q[1:0] != 2'b00);
`else
        errCause[ERR_MISALIGN] = (addr_q[1:0] != 2'b00);
`endif
        errCause[ERR_RANGE]    = (addr_q >= BYTE_LIMIT);
    end

    assign isErr   = |errCause;
    assign wordIdx = addr_q[AW+1:2];
    assign memWe   = (state_q == RESP) && we_q && !isErr;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (memWe),
        .wmask_i (wmask),
        .addr_i  (wordIdx),
        .wdata_i (wdata_q),
        .rdata_o (memRdata)
    );

    assign ack_o   = (state_q == RESP);
    assign err_o   = ack_o && isErr;
    assign rdata_o = (ack_o && !we_q && !isErr) ? memRdata : 32'd0;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Two instances run side by side: one with two wait states, one with none.
// With DMEM_BYTE_EN defined the byte-enable scenario is also exercised.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req2, we2, ack2, err2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        req0, we0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_BYTE_EN
    logic [3:0]  be2, be0;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_STATES(2)) dut2 (
`ifdef DMEM_BYTE_EN
        .be_i    (be2),
`endif
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req2),
        .we_i    (we2),
        .addr_i  (addr2),
        .wdata_i (wdata2),
        .ack_o   (ack2),
        .rdata_o (rdata2),
        .err_o   (err2)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_STATES(0)) dut0 (
`ifdef DMEM_BYTE_EN
        .be_i    (be0),
`endif
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req0),
        .we_i    (we0),
        .addr_i  (addr0),
        .wdata_i (wdata0),
        .ack_o   (ack0),
        .rdata_o (rdata0),
        .err_o   (err0)
    );

    // Runs one complete transaction on the selected instance starting from IDLE,
    // reporting latency, response data, error flag and ack in the following cycle.
    task automatic doTxn(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic er, output logic ackAfter);
        bit done;
        done = 1'b0; lat = -1; rd = '0; er = 1'b0; ackAfter = 1'b0;
        if (sel == 2) begin
            req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk); @(negedge clk);
            if ((sel == 2) ? ack2 : ack0) begin
                lat  = c;
                rd   = (sel == 2) ? rdata2 : rdata0;
                er   = (sel == 2) ? err2 : err0;
                done = 1'b1;
            end
        end
        req2 = 1'b0;
        req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        ackAfter = (sel == 2) ? ack2 : ack0;
        if (!done) begin
            nChecks++; nFails++;
            $display("[TB] FAIL txn_timeout: addr=%h got no ack, required ack within 20 cycles", addr);
        end
    endtask

    // Outputs of both instances must be zero while reset is held.
    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        nChecks++; if (ack2 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_ack2: got %b required 0", ack2); end
        nChecks++; if (err2 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_err2: got %b required 0", err2); end
        nChecks++; if (rdata2 !== 32'd0) begin nFails++; $display("[TB] FAIL reset_rdata2: got %h required 0", rdata2); end
        nChecks++; if (ack0 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_ack0: got %b required 0", ack0); end
        nChecks++; if (rdata0 !== 32'd0) begin nFails++; $display("[TB] FAIL reset_rdata0: got %h required 0", rdata0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Store then load the same word with two wait states.
    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, aa;
        doTxn(2, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, aa);
        nChecks++; if (lat !== 3)   begin nFails++; $display("[TB] FAIL store_latency: got %0d required 3", lat); end
        nChecks++; if (er !== 1'b0) begin nFails++; $display("[TB] FAIL store_err: got %b required 0", er); end
        nChecks++; if (aa !== 1'b0) begin nFails++; $display("[TB] FAIL store_ack_pulse: got %b required 0", aa); end
        doTxn(2, 1'b0, 32'h10, 32'h0, lat, rd, er, aa);
        nChecks++; if (lat !== 3)             begin nFails++; $display("[TB] FAIL load_latency: got %0d required 3", lat); end
        nChecks++; if (rd !== 32'hDEADBEEF)   begin nFails++; $display("[TB] FAIL load_data: got %h required deadbeef", rd); end
        nChecks++; if (er !== 1'b0)           begin nFails++; $display("[TB] FAIL load_err: got %b required 0", er); end
        nChecks++; if (aa !== 1'b0)           begin nFails++; $display("[TB] FAIL load_ack_pulse: got %b required 0", aa); end
    endtask

    // Misaligned and out-of-range accesses flag an error and never write.
    task automatic test_errors();
        int lat; logic [31:0] rd; logic er, aa;
        doTxn(2, 1'b1, 32'h0, 32'hA5A50000, lat, rd, er, aa);
        nChecks++; if (er !== 1'b0) begin nFails++; $display("[TB] FAIL prestore_err: got %b required 0", er); end
        doTxn(2, 1'b0, 32'h6, 32'h0, lat, rd, er, aa);
        nChecks++; if (er !== 1'b1)    begin nFails++; $display("[TB] FAIL misalign_err: got %b required 1", er); end
        nChecks++; if (rd !== 32'd0)   begin nFails++; $display("[TB] FAIL misalign_rdata: got %h required 0", rd); end
        nChecks++; if (lat !== 3)      begin nFails++; $display("[TB] FAIL misalign_latency: got %0d required 3", lat); end
        doTxn(2, 1'b0, 32'h200, 32'h0, lat, rd, er, aa);
        nChecks++; if (er !== 1'b1)    begin nFails++; $display("[TB] FAIL range_err: got %b required 1", er); end
        nChecks++; if (rd !== 32'd0)   begin nFails++; $display("[TB] FAIL range_rdata: got %h required 0", rd); end
        // 0x200 aliases word 0 and 0x12 aliases word 4 if the checks were missing.
        doTxn(2, 1'b1, 32'h200, 32'h12345678, lat, rd, er, aa);
        nChecks++; if (er !== 1'b1)    begin nFails++; $display("[TB] FAIL range_store_err: got %b required 1", er); end
        doTxn(2, 1'b1, 32'h12, 32'h0BAD0BAD, lat, rd, er, aa);
        nChecks++; if (er !== 1'b1)    begin nFails++; $display("[TB] FAIL misalign_store_err: got %b required 1", er); end
        doTxn(2, 1'b0, 32'h0, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'hA5A50000) begin nFails++; $display("[TB] FAIL word0_intact: got %h required a5a50000", rd); end
        doTxn(2, 1'b0, 32'h10, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL word4_intact: got %h required deadbeef", rd); end
    endtask

    // Reset during WAIT of a store drops it without ack and without writing.
    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er, aa; bit sawAck;
        doTxn(2, 1'b1, 32'h20, 32'h00002020, lat, rd, er, aa);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0; req2 = 1'b0;
        #1;
        nChecks++; if (ack2 !== 1'b0)    begin nFails++; $display("[TB] FAIL midreset_ack: got %b required 0", ack2); end
        nChecks++; if (rdata2 !== 32'd0) begin nFails++; $display("[TB] FAIL midreset_rdata: got %h required 0", rdata2); end
        @(posedge clk); @(negedge clk);
        nChecks++; if (err2 !== 1'b0)    begin nFails++; $display("[TB] FAIL midreset_err: got %b required 0", err2); end
        rst_n = 1'b1;
        sawAck = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (ack2) sawAck = 1'b1;
        end
        nChecks++; if (sawAck !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_no_ack: got ack=1 required no ack"); end
        doTxn(2, 1'b0, 32'h20, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'h00002020) begin nFails++; $display("[TB] FAIL midreset_prior_value: got %h required 00002020", rd); end
    endtask

    // Request fields changed after capture must be ignored.
    task automatic test_capture();
        int lat; logic [31:0] rd; logic er, aa; logic erAck;
        doTxn(2, 1'b1, 32'h34, 32'h00000034, lat, rd, er, aa);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h30; wdata2 = 32'h30303030;
        @(posedge clk); @(negedge clk);
        addr2 = 32'h34; wdata2 = 32'h34343434;
        lat = -1; erAck = 1'b1;
        for (int c = 2; c <= 20 && lat < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (ack2) begin lat = c; erAck = err2; end
        end
        req2 = 1'b0;
        @(posedge clk); @(negedge clk);
        nChecks++; if (lat !== 3)      begin nFails++; $display("[TB] FAIL capture_latency: got %0d required 3", lat); end
        nChecks++; if (erAck !== 1'b0) begin nFails++; $display("[TB] FAIL capture_err: got %b required 0", erAck); end
        doTxn(2, 1'b0, 32'h30, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'h30303030) begin nFails++; $display("[TB] FAIL capture_orig_addr: got %h required 30303030", rd); end
        doTxn(2, 1'b0, 32'h34, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'h00000034) begin nFails++; $display("[TB] FAIL capture_other_addr: got %h required 00000034", rd); end
    endtask

    // Zero wait states with req held high: acks land in cycles 1 and 3.
    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, aa;
        logic [3:0]  pattern;
        logic [31:0] rd1, rd3;
        doTxn(0, 1'b1, 32'h0, 32'h01010101, lat, rd, er, aa);
        nChecks++; if (lat !== 1) begin nFails++; $display("[TB] FAIL ws0_latency: got %0d required 1", lat); end
        doTxn(0, 1'b1, 32'h4, 32'h02020202, lat, rd, er, aa);
        pattern = 4'b0; rd1 = '0; rd3 = '0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); @(negedge clk);
            pattern[c-1] = ack0;
            if (c == 1) begin rd1 = rdata0; addr0 = 32'h4; end
            if (c == 3) begin rd3 = rdata0; req0 = 1'b0; end
        end
        @(posedge clk); @(negedge clk);
        nChecks++; if (pattern !== 4'b0101) begin nFails++; $display("[TB] FAIL b2b_ack_pattern: got %b required 0101", pattern); end
        nChecks++; if ((pattern & (pattern >> 1)) !== 4'b0) begin nFails++; $display("[TB] FAIL b2b_consecutive_ack: got %b required no adjacent ones", pattern); end
        nChecks++; if (rd1 !== 32'h01010101) begin nFails++; $display("[TB] FAIL b2b_first_data: got %h required 01010101", rd1); end
        nChecks++; if (rd3 !== 32'h02020202) begin nFails++; $display("[TB] FAIL b2b_second_data: got %h required 02020202", rd3); end
    endtask

`ifdef DMEM_BYTE_EN
    // Byte-masked stores merge into the existing word; an empty mask is a no-op.
    task automatic test_byte_en();
        int lat; logic [31:0] rd; logic er, aa;
        be2 = 4'hF;
        doTxn(2, 1'b1, 32'h8, 32'h11223344, lat, rd, er, aa);
        be2 = 4'b0101;
        doTxn(2, 1'b1, 32'h8, 32'hAABBCCDD, lat, rd, er, aa);
        nChecks++; if (er !== 1'b0) begin nFails++; $display("[TB] FAIL be_store_err: got %b required 0", er); end
        be2 = 4'b0000;
        doTxn(2, 1'b1, 32'h8, 32'h99999999, lat, rd, er, aa);
        nChecks++; if (lat !== 3) begin nFails++; $display("[TB] FAIL be_noop_ack: got latency %0d required 3", lat); end
        be2 = 4'hF;
        doTxn(2, 1'b0, 32'h8, 32'h0, lat, rd, er, aa);
        nChecks++; if (rd !== 32'h11BB33DD) begin nFails++; $display("[TB] FAIL be_merge: got %h required 11bb33dd", rd); end
    endtask
`endif

    // Scenario sequence and final summary.
    initial begin
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
`ifdef DMEM_BYTE_EN
        be2 = 4'hF; be0 = 4'hF;
`endif
        test_reset();
        test_store_load();
        test_errors();
        test_reset_mid();
        test_capture();
        test_back_to_back();
`ifdef DMEM_BYTE_EN
        test_byte_en();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000 ns, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_dmem_responder
